// File: rtl/audio_pwm_out.sv
// Audio playback stage: sample FIFO, ~32 kHz sample tick, offset-binary PWM drive.
// Optional `PWM_DITHER_EN adds LFSR dither ahead of duty truncation.
module audio_pwm_out #(
    parameter int SAMPLE_DIV = 3125,
    parameter int PWM_BITS   = 8,
    parameter int FIFO_AW    = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [15:0]        sample_in,
    input  logic               sample_valid,
    output logic               sample_ready,
    output logic               sample_tick,
    output logic [FIFO_AW:0]   fifo_level,
    output logic               underrun,
    output logic               aud_pwm,
    output logic               aud_sd
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int TW    = $clog2(SAMPLE_DIV);
    localparam logic [TW-1:0]       TICK_MAX = TW'(SAMPLE_DIV - 1);
    localparam logic [PWM_BITS-1:0] MID      = {1'b1, {(PWM_BITS-1){1'b0}}};

    logic [TW-1:0]       r_tick_cnt;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [PWM_BITS-1:0] r_duty_pend;
    logic [PWM_BITS-1:0] r_duty_act;
    logic                r_pwm;
    logic                r_sd;
    logic [15:0]         r_mem [DEPTH];
    logic [FIFO_AW-1:0]  r_wr;
    logic [FIFO_AW-1:0]  r_rd;
    logic [FIFO_AW:0]    r_level;

    logic                w_full, w_empty, w_push, w_pop, w_wrap;
    logic [15:0]         w_u;
    logic [PWM_BITS-1:0] w_duty;

    assign w_full       = (r_level == (FIFO_AW+1)'(DEPTH));
    assign w_empty      = (r_level == '0);
    assign sample_ready = !w_full;
    assign sample_tick  = enable && (r_tick_cnt == TICK_MAX);
    assign underrun     = sample_tick && w_empty;
    assign fifo_level   = r_level;
    assign aud_pwm      = r_pwm;
    assign aud_sd       = r_sd;

    // Push is decided on the pre-pop level, so a full FIFO never accepts even while popping.
    assign w_push = sample_valid && !w_full;
    assign w_pop  = sample_tick && !w_empty;
    assign w_wrap = enable && (r_pwm_cnt == '1);
    assign w_u    = r_mem[r_rd] ^ 16'h8000;

`ifdef PWM_DITHER_EN
    localparam logic [15:0] DMASK = 16'((32'd1 << (16 - PWM_BITS)) - 32'd1);
    logic [15:0] r_lfsr;
    logic [15:0] w_lfsr_next;
    logic [16:0] w_sum;
    logic [15:0] w_dith;

    // Right-shifting Galois form of x^16+x^14+x^13+x^11+1.
    assign w_lfsr_next = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
    assign w_sum       = {1'b0, w_u} + {1'b0, r_lfsr & DMASK};
    assign w_dith      = w_sum[16] ? 16'hFFFF : w_sum[15:0];
    assign w_duty      = w_dith[15 -: PWM_BITS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)              r_lfsr <= 16'hACE1;
        else if (sample_tick) r_lfsr <= w_lfsr_next;
    end
`else
    assign w_duty = w_u[15 -: PWM_BITS];
`endif

    // Storage has no reset; pointer/level reset is what empties the FIFO.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= sample_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + FIFO_AW'(1);
            if (w_pop)  r_rd <= r_rd + FIFO_AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + (FIFO_AW+1)'(1);
                2'b01:   r_level <= r_level - (FIFO_AW+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tick_cnt <= '0;
            r_pwm_cnt  <= '0;
        end else if (!enable) begin
            r_tick_cnt <= '0;
            r_pwm_cnt  <= '0;
        end else begin
            r_tick_cnt <= (r_tick_cnt == TICK_MAX) ? '0 : r_tick_cnt + TW'(1);
            r_pwm_cnt  <= r_pwm_cnt + PWM_BITS'(1);
        end
    end

    // Active duty only changes as the counter wraps, so a period is never split.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_duty_pend <= MID;
            r_duty_act  <= MID;
            r_pwm       <= 1'b0;
            r_sd        <= 1'b0;
        end else begin
            if (w_pop)  r_duty_pend <= w_duty;
            if (w_wrap) r_duty_act  <= r_duty_pend;
            r_pwm <= enable && (r_pwm_cnt < r_duty_act);
            r_sd  <= enable;
        end
    end
endmodule

// File: tb/tb_audio_pwm_out.sv
// Randomized + directed bench for audio_pwm_out against a queue-based playback model.
module tb_audio_pwm_out;
    localparam int DIV = 300, PB = 8, AW = 2, DEPTH = 4, P = 256;

    logic clk = 1'b0;
    logic rst, enable, sample_valid;
    logic [15:0] sample_in;
    logic sample_ready, sample_tick, underrun, aud_pwm, aud_sd;
    logic [AW:0] fifo_level;

    always #5 clk = ~clk;

    audio_pwm_out #(.SAMPLE_DIV(DIV), .PWM_BITS(PB), .FIFO_AW(AW)) dut (
        .clk(clk), .rst(rst), .enable(enable), .sample_in(sample_in),
        .sample_valid(sample_valid), .sample_ready(sample_ready),
        .sample_tick(sample_tick), .fifo_level(fifo_level), .underrun(underrun),
        .aud_pwm(aud_pwm), .aud_sd(aud_sd));

    int total = 0, bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: playback state in plain terms.
    logic [15:0] m_q[$];
    int m_en, m_pend, m_act;
    bit m_pwm, m_sd;
    logic [15:0] m_lfsr;

    int cyc, n_ticks, n_under, first_tick, last_tick;
    bit pwm_log [4096];
    bit rdy_log [4096];
    int lvl_log [4096];

    function automatic int conv(input logic [15:0] s);
        int u;
        u = int'(s ^ 16'h8000);
`ifdef PWM_DITHER_EN
        u = u + int'(m_lfsr % (16'd1 << (16 - PB)));
        if (u > 65535) u = 65535;
`endif
        return u / (1 << (16 - PB));
    endfunction

    task automatic m_reset();
        m_q.delete();
        m_en = 0; m_pend = P / 2; m_act = P / 2;
        m_pwm = 0; m_sd = 0; m_lfsr = 16'hACE1;
    endtask

    task automatic step();
        bit exp_tick;
        int sz;
        @(negedge clk);
        sz = m_q.size();
        exp_tick = enable && (m_en % DIV == DIV - 1);
        chk("sample_tick", sample_tick, exp_tick);
        chk("sample_ready", sample_ready, sz < DEPTH);
        chk("fifo_level", fifo_level, sz);
        chk("underrun", underrun, exp_tick && sz == 0);
        chk("aud_pwm", aud_pwm, m_pwm);
        chk("aud_sd", aud_sd, m_sd);
        if (cyc < 4096) begin
            pwm_log[cyc] = aud_pwm;
            rdy_log[cyc] = sample_ready;
            lvl_log[cyc] = int'(fifo_level);
        end
        if (sample_tick === 1'b1) begin
            n_ticks++;
            if (first_tick < 0) first_tick = cyc;
            last_tick = cyc;
        end
        if (underrun === 1'b1) n_under++;
        @(posedge clk);
        m_pwm = enable && (m_en % P < m_act);
        if (enable && (m_en % P == P - 1)) m_act = m_pend;
        if (exp_tick && sz > 0) m_pend = conv(m_q.pop_front());
        if (exp_tick) m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
        if (sample_valid && sz < DEPTH) m_q.push_back(sample_in);
        m_sd = enable;
        m_en = enable ? m_en + 1 : 0;
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        m_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0; n_ticks = 0; n_under = 0; first_tick = -1; last_tick = -1;
    endtask

    function automatic int hi(input int a, input int b);
        int n = 0;
        for (int i = a; i <= b; i++) n += int'(pwm_log[i]);
        return n;
    endfunction

    task automatic run_to(input int c);
        while (cyc < c) step();
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] d [5];
        int k, g;
        rst = 1'b1; enable = 1'b0; sample_valid = 1'b0; sample_in = '0;
        m_reset();
        #12;
        chk("rst_tick", sample_tick, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_ready", sample_ready, 1);
        chk("rst_underrun", underrun, 0);
        chk("rst_pwm", aud_pwm, 0);
        chk("rst_sd", aud_sd, 0);

        // Tick pacing and underrun with an empty FIFO; duty stays midscale.
        enable = 1'b1;
        do_reset();
        run_to(905);
        chk("first_tick", first_tick, 299);
        chk("last_tick", last_tick, 899);
        chk("tick_count", n_ticks, 3);
        chk("underrun_count", n_under, 3);
        chk("mid_duty_p0", hi(1, 256), 128);
        chk("mid_duty_p2", hi(513, 768), 128);

        // Full-scale, midscale and zero duty in successive periods.
        do_reset();
        sample_valid = 1'b1;
        sample_in = 16'h7FFF; step();
        sample_in = 16'h0000; step();
        sample_in = 16'h8000; step();
        sample_valid = 1'b0;
        run_to(1290);
        chk("duty_255", hi(513, 768), 255);
        chk("duty_128", hi(769, 1024), 128);
        chk("duty_0", hi(1025, 1280), 0);

        // Overfill: fifth sample waits for the first pop.
        do_reset();
        d[0] = 16'h1000; d[1] = 16'h2000; d[2] = 16'h3000; d[3] = 16'h6000; d[4] = 16'h7F00;
        k = 0; g = 0;
        while (k < 5 && g < 400) begin
            sample_valid = 1'b1;
            sample_in = d[k];
            step();
            if (rdy_log[cyc - 1]) k++;
            g++;
        end
        sample_valid = 1'b0;
        chk("ready_low_full", rdy_log[4], 0);
        chk("level_full", lvl_log[4], 4);
        chk("push5_cycle", cyc, 301);
        run_to(302);
        chk("level_after5", lvl_log[301], 4);

        // Push on the tick cycle at level 2; oldest entry is the one popped.
        run_to(1199);
        sample_valid = 1'b1; sample_in = 16'h1234;
        step();
        sample_valid = 1'b0;
        run_to(1540);
        chk("level_tick_push", lvl_log[1199], 2);
        chk("level_after_tick", lvl_log[1200], 2);
        chk("oldest_duty", hi(1281, 1536), 224);

        // Asynchronous reset while the output is high with samples queued.
        do_reset();
        sample_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin sample_in = 16'h7FFF; step(); end
        sample_valid = 1'b0;
        g = 0;
        while (aud_pwm !== 1'b1 && g < 300) begin step(); g++; end
        chk("pwm_high_before_rst", aud_pwm, 1);
        chk("queued_before_rst", fifo_level, 3);
        #2 rst = 1'b1;
        #1;
        chk("arst_pwm", aud_pwm, 0);
        chk("arst_level", fifo_level, 0);
        chk("arst_ready", sample_ready, 1);
        m_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        cyc = 0; n_ticks = 0; n_under = 0; first_tick = -1;
        run_to(610);
        chk("post_rst_mid", hi(1, 256), 128);
        chk("post_rst_underrun", n_under, 2);

        // Random traffic with occasional enable drops.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 399) == 0) enable = !enable;
            sample_valid = ((i / 1000) % 2 == 0) ? ($urandom_range(0, 99) < 3)
                                                 : ($urandom_range(0, 999) < 2);
            sample_in = 16'($urandom);
            step();
        end
        enable = 1'b1;
        sample_valid = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
